// File: rtl/ir_ctrl_pkg.sv
// ir_ctrl_pkg: shared types, NEC code constants and decode helpers for the IR direction controller.
package ir_ctrl_pkg;
  typedef enum logic [1:0] {UP = 2'b00, RIGHT = 2'b01, DOWN = 2'b10, LEFT = 2'b11} dir_t;
  typedef enum logic [1:0] {IDLE, CAPT, HOLD} state_t;
  typedef struct packed {
    logic valid;
    dir_t dir;
  } dec_t;
  localparam logic [7:0] NEC_ADDR  = 8'h20;
  localparam logic [7:0] CMD_UP    = 8'h6A;
  localparam logic [7:0] CMD_DOWN  = 8'hEA;
  localparam logic [7:0] CMD_LEFT  = 8'h1A;
  localparam logic [7:0] CMD_RIGHT = 8'h9A;
  function automatic dec_t cmd_to_dir(input logic [7:0] cmd);
    dec_t d;
    d.valid = cmd inside {CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT};
    d.dir = cmd == CMD_UP ? UP : cmd == CMD_DOWN ? DOWN : cmd == CMD_LEFT ? LEFT : RIGHT;
    return d;
  endfunction
  function automatic logic is_reversal(input dir_t a, input dir_t b);
    return (a ^ b) == 2'b10;
  endfunction
endpackage

// File: rtl/ir_dir_controller_dir_fifo.sv
// dir_fifo: synchronous FIFO of directions; a push into a full queue succeeds only alongside a pop.
module dir_fifo
  import ir_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  dir_t din,
  output logic full,
  output logic empty,
  output dir_t head
);
  localparam int AW = $clog2(DEPTH);
  dir_t mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head = empty ? UP : mem_q[rd_q[AW-1:0]];
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= UP;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end
  end
endmodule

// File: rtl/ir_dir_controller.sv
// ir_dir_controller: captures NEC code words, maps them to queued snake directions, holds the receiver in reset as a hold-off.
// Define IR_FULL_CODE_CHECK_EN to also require the address 0x20 and both inverse bytes to match.
module ir_dir_controller
  import ir_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 2000,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic        nec_clk,
  input  logic        reset_n,
  input  logic [31:0] word,
  output logic        rx_reset_n,
  output logic [1:0]  dir,
  output logic        dir_valid,
  input  logic        dir_ready,
  output logic [7:0]  drop_count,
  output logic        busy
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
  state_t state_q, state_d;
  logic [31:0] cap_q, cap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] drop_q, drop_d;
  dir_t last_q, last_d;
  logic rx_q, rx_d;
  dec_t dec;
  logic code_ok, push, full, empty;
  dir_t head;
  always_comb begin
    dec = cmd_to_dir(cap_q[15:8]);
`ifdef IR_FULL_CODE_CHECK_EN
    code_ok = dec.valid && cap_q[15:8] == ~cap_q[7:0] && cap_q[23:16] == ~cap_q[31:24]
              && cap_q[31:24] == NEC_ADDR;
`else
    code_ok = dec.valid;
`endif
    push = state_q == CAPT && code_ok && !is_reversal(dec.dir, last_q) && (!full || (dir_ready && !empty));
  end
  // rx_reset_n is registered, so it drops on entering HOLD and rises together with the return to IDLE
  always_comb begin
    state_d = state_q;
    cap_d = cap_q;
    cnt_d = cnt_q;
    drop_d = drop_q;
    last_d = last_q;
    rx_d = 1'b1;
    case (state_q)
      IDLE: if (word != '0) begin
        state_d = CAPT;
        cap_d = word;
      end
      CAPT: begin
        state_d = HOLD;
        cnt_d = '0;
        rx_d = 1'b0;
        if (push) last_d = dec.dir;
        else drop_d = drop_q + {7'd0, drop_q != 8'hFF};
      end
      HOLD: begin
        cnt_d = cnt_q + CW'(1);
        state_d = cnt_q == LAST ? IDLE : HOLD;
        rx_d = cnt_q == LAST;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge nec_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cap_q <= '0;
      cnt_q <= '0;
      drop_q <= '0;
      last_q <= RIGHT;
      rx_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q <= cap_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
      last_q <= last_d;
      rx_q <= rx_d;
    end
  end
  dir_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(nec_clk),
    .rst_n(reset_n),
    .push(push),
    .pop(dir_ready),
    .din(dec.dir),
    .full(full),
    .empty(empty),
    .head(head)
  );
  assign rx_reset_n = rx_q;
  assign dir = head;
  assign dir_valid = !empty;
  assign drop_count = drop_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_ir_dir_controller.sv
// tb_ir_dir_controller: randomized and directed stimulus against a queue-based reference model of the controller.
module tb_ir_dir_controller;
  localparam int HOLD = 2000;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic reset_n;
  logic [31:0] word = '0;
  logic dir_ready = 1'b0;
  logic rx_reset_n, dir_valid, busy;
  logic [1:0] dir;
  logic [7:0] drop_count;
  logic [31:0] word2 = '0;
  logic rx2, dv2, busy2;
  logic [1:0] dir2;
  logic [7:0] drop2;
  int tests = 0, fails = 0;
  bit chk_on = 0, rnd_ready = 0;
  always #5 clk = ~clk;

  ir_dir_controller #(.HOLD_CYCLES(HOLD), .FIFO_DEPTH(DEPTH)) dut (
    .nec_clk(clk), .reset_n(reset_n), .word(word), .rx_reset_n(rx_reset_n), .dir(dir),
    .dir_valid(dir_valid), .dir_ready(dir_ready), .drop_count(drop_count), .busy(busy)
  );
  // short hold-off instance used only to reach drop counter saturation quickly
  ir_dir_controller #(.HOLD_CYCLES(8), .FIFO_DEPTH(4)) sat (
    .nec_clk(clk), .reset_n(reset_n), .word(word2), .rx_reset_n(rx2), .dir(dir2),
    .dir_valid(dv2), .dir_ready(1'b0), .drop_count(drop2), .busy(busy2)
  );

  // reference model: queue of directions, cycles since capture, last enqueued direction
  int q[$];
  int m_last, m_drop, m_tcap, m_d;
  bit m_started, m_pop, m_room;
  logic [31:0] m_cap;
  function automatic int decode(input logic [31:0] w);
    int d;
    case (w[15:8])
      8'h6A: d = 0;
      8'h9A: d = 1;
      8'hEA: d = 2;
      8'h1A: d = 3;
      default: d = -1;
    endcase
`ifdef IR_FULL_CODE_CHECK_EN
    if (w[31:24] != 8'h20 || (w[23:16] ^ w[31:24]) != 8'hFF || (w[15:8] ^ w[7:0]) != 8'hFF) d = -1;
`endif
    return d;
  endfunction
  always @(posedge clk) begin
    if (!reset_n) begin
      q.delete();
      m_last = 1;
      m_drop = 0;
      m_tcap = -1;
      m_started = 0;
    end else begin
      m_pop = dir_ready && q.size() > 0;
      m_room = q.size() < DEPTH || m_pop;
      if (m_pop) void'(q.pop_front());
      if (m_tcap < 0) begin
        if (word != 0) begin
          m_tcap = 0;
          m_cap = word;
        end
      end else if (m_tcap == 0) begin
        m_d = decode(m_cap);
        if (m_d >= 0 && (m_d + 2) % 4 != m_last && m_room) begin
          q.push_back(m_d);
          m_last = m_d;
        end else if (m_drop < 255) m_drop++;
        m_tcap = 1;
      end else m_tcap = (m_tcap == HOLD) ? -1 : m_tcap + 1;
      m_started = 1;
    end
  end

  logic [12:0] exp_v, got_v;
  int hd;
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      hd = q.size() > 0 ? q[0] : 0;
      exp_v = {m_tcap >= 0, m_started && m_tcap < 1, q.size() > 0, hd[1:0], m_drop[7:0]};
      got_v = {busy, rx_reset_n, dir_valid, dir, drop_count};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL model t=%0t busy/rx/valid/dir/drop got %b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
                 $time, got_v[12], got_v[11], got_v[10], got_v[9:8], got_v[7:0],
                 exp_v[12], exp_v[11], exp_v[10], exp_v[9:8], exp_v[7:0]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    dir_ready = 1'b0;
    word = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      if (rnd_ready) dir_ready = $urandom_range(0, 499) == 0;
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", busy, 0);
    if (rnd_ready) dir_ready = 1'b0;
  endtask
  task automatic send(input logic [31:0] code, input bit pulse);
    wait_idle();
    word = code;
    @(negedge clk);
    if (pulse) dir_ready = 1'b1;
    @(negedge clk);
    dir_ready = 1'b0;
    word = '0;
    wait_idle();
  endtask
  task automatic pop_one();
    @(negedge clk);
    dir_ready = 1'b1;
    @(negedge clk);
    dir_ready = 1'b0;
  endtask

  initial begin
    int n;
    bit busy_all;
    logic [7:0] cmd;
    logic [31:0] code;
    logic [7:0] cmds [4];
    cmds = '{8'h6A, 8'h9A, 8'hEA, 8'h1A};
    reset_n = 1'b0;
    do_reset();
    chk_on = 1;
    check("reset_rx", rx_reset_n, 1);
    check("reset_valid", dir_valid, 0);
    // latency and exact hold-off length
    wait_idle();
    word = 32'h20DF6A95;
    @(posedge clk) #1;
    check("t1_busy_capt", busy, 1);
    check("t1_valid_early", dir_valid, 0);
    @(posedge clk) #1;
    word = '0;
    check("t1_valid", dir_valid, 1);
    check("t1_dir", dir, 0);
    check("t1_rx_low", rx_reset_n, 0);
    n = 1;
    busy_all = 1;
    while (n < 3000) begin
      @(posedge clk) #1;
      if (rx_reset_n) break;
      busy_all &= busy;
      n++;
    end
    check("t1_hold_len", n, HOLD);
    check("t1_busy_hold", busy_all, 1);
    check("t1_busy_end", busy, 0);
    // reversal rejection against last enqueued direction
    do_reset();
    send(32'h20DF9A65, 0);
    send(32'h20DF1AE5, 0);
    check("t2_drop", drop_count, 1);
    send(32'h20DF6A95, 0);
    check("t2_head", dir, 1);
    pop_one();
    check("t2_second", dir, 0);
    check("t2_valid", dir_valid, 1);
    // full queue: drop without pop, accept with pop in the decode cycle
    do_reset();
    send(32'h20DF6A95, 0);
    send(32'h20DF9A65, 0);
    send(32'h20DFEA15, 0);
    check("t3_full_drop", drop_count, 1);
    send(32'h20DFEA15, 1);
    check("t3_pop_push_drop", drop_count, 1);
    check("t3_head", dir, 1);
    pop_one();
    check("t3_tail", dir, 2);
    pop_one();
    pop_one();
    check("t3_empty", dir_valid, 0);
    // invalid command and address checking
    do_reset();
    send(32'h20DF0000, 0);
    check("t4_bad_cmd", drop_count, 1);
    send(32'h21DE6A95, 0);
`ifdef IR_FULL_CODE_CHECK_EN
    check("t4_bad_addr_drop", drop_count, 2);
    check("t4_bad_addr_valid", dir_valid, 0);
`else
    check("t4_addr_ignored_drop", drop_count, 1);
    check("t4_addr_ignored_valid", dir_valid, 1);
    check("t4_addr_ignored_dir", dir, 0);
`endif
    // asynchronous reset in the middle of the hold-off
    do_reset();
    send(32'h20DF0000, 0);
    wait_idle();
    word = 32'h20DF6A95;
    @(negedge clk);
    @(negedge clk);
    word = '0;
    repeat (499) @(negedge clk);
    check("t5_pre_busy", busy, 1);
    reset_n = 1'b0;
    @(posedge clk) #1;
    check("t5_busy", busy, 0);
    check("t5_valid", dir_valid, 0);
    check("t5_rx", rx_reset_n, 0);
    check("t5_drop", drop_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    // randomized codes with sparse random pops
    rnd_ready = 1;
    for (int i = 0; i < 14; i++) begin
      cmd = cmds[$urandom_range(0, 3)];
      case ($urandom_range(0, 3))
        0, 1: code = {8'h20, 8'hDF, cmd, ~cmd};
        2: code = {8'h20, 8'hDF, 8'($urandom), 8'($urandom)};
        default: code = $urandom | 32'h1;
      endcase
      send(code, 1'($urandom_range(0, 1)));
    end
    rnd_ready = 0;
    dir_ready = 1'b0;
    // drop counter saturation on the short hold-off instance
    for (int i = 0; i < 300; i++) begin
      n = 0;
      while (busy2 && n < 100) begin
        @(negedge clk);
        n++;
      end
      word2 = 32'h20DF0000;
      @(negedge clk);
      word2 = '0;
      n = 0;
      while (busy2 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("sat_drop", drop2, i < 255 ? i + 1 : 255);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
